// File: rtl/chess_board_mem.sv
// Board-state store: 8x8 piece codes, registered view read port, move executor with valid/ready handshake.
// Optional BOARD_PROMOTION_EN: pawns reaching the far rank are stored as a queen of the same colour.
//
// state       | meaning
// S_INIT      | writing the starting position, one square per cycle
// S_IDLE      | ready for a move or a new-game request
// S_READ_SRC  | latch source/destination pieces, classify the move
// S_WRITE_DST | write moving piece to destination
// S_CLEAR_SRC | empty the source square
// S_DONE      | pulse move_done or move_err, then back to idle
module chess_board_mem #(
    parameter int INIT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] view_x,
    input  logic [2:0] view_y,
    output logic [3:0] piece_out,
    input  logic       new_game,
    input  logic       move_valid,
    output logic       move_ready,
    input  logic [2:0] from_x,
    input  logic [2:0] from_y,
    input  logic [2:0] to_x,
    input  logic [2:0] to_y,
    output logic       move_done,
    output logic       move_err,
    output logic [3:0] captured,
    output logic       init_busy,
    output logic       board_changed
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_READ_SRC,
        S_WRITE_DST,
        S_CLEAR_SRC,
        S_DONE
    } state_t;

    state_t     state_q;
    logic [5:0] init_cnt_q;
    logic [5:0] src_idx_q;
    logic [5:0] dst_idx_q;
    logic [3:0] src_piece_q;
    logic [3:0] dst_piece_q;
    logic [3:0] piece_out_q;
    logic [3:0] captured_q;
    logic       move_ready_q;
    logic       move_done_q;
    logic       move_err_q;
    logic       init_busy_q;
    logic       board_changed_q;
    logic [3:0] board_q [64];
    logic [3:0] wr_piece;

    // Index is {y, x}; y=0/1 are black, y=6/7 are white.
    function automatic logic [3:0] start_piece(input logic [5:0] idx);
        logic [2:0] back;
        logic [3:0] code;
        case (idx[2:0])
            3'd0, 3'd7: back = 3'd4;
            3'd1, 3'd6: back = 3'd2;
            3'd2, 3'd5: back = 3'd3;
            3'd3:       back = 3'd5;
            default:    back = 3'd6;
        endcase
        case (idx[5:3])
            3'd0:    code = {1'b1, back};
            3'd1:    code = 4'h9;
            3'd6:    code = 4'h1;
            3'd7:    code = {1'b0, back};
            default: code = 4'h0;
        endcase
        return code;
    endfunction

`ifdef BOARD_PROMOTION_EN
    logic promote;
    assign promote  = (src_piece_q[2:0] == 3'd1) &&
                      ((!src_piece_q[3] && (dst_idx_q[5:3] == 3'd0)) ||
                       ( src_piece_q[3] && (dst_idx_q[5:3] == 3'd7)));
    assign wr_piece = promote ? {src_piece_q[3], 3'd5} : src_piece_q;
`else
    assign wr_piece = src_piece_q;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= S_INIT;
            init_cnt_q      <= 6'd0;
            src_idx_q       <= 6'd0;
            dst_idx_q       <= 6'd0;
            src_piece_q     <= 4'h0;
            dst_piece_q     <= 4'h0;
            piece_out_q     <= 4'h0;
            captured_q      <= 4'h0;
            move_ready_q    <= 1'b0;
            move_done_q     <= 1'b0;
            move_err_q      <= 1'b0;
            init_busy_q     <= 1'b1;
            board_changed_q <= 1'b0;
        end else begin
            piece_out_q     <= init_busy_q ? 4'h0 : board_q[{view_y, view_x}];
            move_done_q     <= 1'b0;
            move_err_q      <= 1'b0;
            board_changed_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    board_q[init_cnt_q] <= start_piece(init_cnt_q);
                    init_cnt_q          <= init_cnt_q + 6'd1;
                    if (init_cnt_q == 6'(INIT_CYCLES - 1)) begin
                        state_q         <= S_IDLE;
                        init_busy_q     <= 1'b0;
                        move_ready_q    <= 1'b1;
                        board_changed_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (new_game) begin
                        state_q      <= S_INIT;
                        init_cnt_q   <= 6'd0;
                        init_busy_q  <= 1'b1;
                        move_ready_q <= 1'b0;
                    end else if (move_valid && move_ready_q) begin
                        src_idx_q    <= {from_y, from_x};
                        dst_idx_q    <= {to_y, to_x};
                        move_ready_q <= 1'b0;
                        state_q      <= S_READ_SRC;
                    end
                end
                S_READ_SRC: begin
                    src_piece_q <= board_q[src_idx_q];
                    dst_piece_q <= board_q[dst_idx_q];
                    if (board_q[src_idx_q] == 4'h0) begin
                        move_err_q <= 1'b1;
                        captured_q <= 4'h0;
                        state_q    <= S_DONE;
                    end else if (src_idx_q == dst_idx_q) begin
                        move_done_q <= 1'b1;
                        captured_q  <= 4'h0;
                        state_q     <= S_DONE;
                    end else begin
                        state_q <= S_WRITE_DST;
                    end
                end
                S_WRITE_DST: begin
                    board_q[dst_idx_q] <= wr_piece;
                    state_q            <= S_CLEAR_SRC;
                end
                S_CLEAR_SRC: begin
                    // Completion flags are raised here so they are visible during DONE.
                    board_q[src_idx_q] <= 4'h0;
                    move_done_q        <= 1'b1;
                    board_changed_q    <= 1'b1;
                    captured_q         <= dst_piece_q;
                    state_q            <= S_DONE;
                end
                S_DONE: begin
                    move_ready_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q      <= S_INIT;
                    init_cnt_q   <= 6'd0;
                    init_busy_q  <= 1'b1;
                    move_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign piece_out     = piece_out_q;
    assign move_ready    = move_ready_q;
    assign move_done     = move_done_q;
    assign move_err      = move_err_q;
    assign captured      = captured_q;
    assign init_busy     = init_busy_q;
    assign board_changed = board_changed_q;

endmodule

// File: tb/tb_chess_board_mem.sv
// Self-checking bench for chess_board_mem against a square-array model of the board rules.
module tb_chess_board_mem;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] view_x = 3'd0, view_y = 3'd0;
    logic [2:0] from_x = 3'd0, from_y = 3'd0, to_x = 3'd0, to_y = 3'd0;
    logic       new_game = 1'b0, move_valid = 1'b0;
    logic [3:0] piece_out, captured;
    logic       move_ready, move_done, move_err, init_busy, board_changed;

    int checks = 0;
    int failures = 0;
    logic [3:0] model [64];
    int back_rank [8] = '{4, 2, 3, 5, 6, 3, 2, 4};

    chess_board_mem #(.INIT_CYCLES(64)) dut (
        .clk(clk), .resetn(resetn), .view_x(view_x), .view_y(view_y),
        .piece_out(piece_out), .new_game(new_game), .move_valid(move_valid),
        .move_ready(move_ready), .from_x(from_x), .from_y(from_y), .to_x(to_x),
        .to_y(to_y), .move_done(move_done), .move_err(move_err), .captured(captured),
        .init_busy(init_busy), .board_changed(board_changed)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] start_code(int x, int y);
        case (y)
            0: return 4'(8 + back_rank[x]);
            1: return 4'h9;
            6: return 4'h1;
            7: return 4'(back_rank[x]);
            default: return 4'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model[i] = start_code(i % 8, i / 8);
    endtask

    task automatic model_apply(input int fx, input int fy, input int tx, input int ty);
        logic [3:0] p;
        p = model[fy*8 + fx];
        if (p == 4'h0 || (fx == tx && fy == ty)) return;
`ifdef BOARD_PROMOTION_EN
        if (p == 4'h1 && ty == 0) p = 4'h5;
        if (p == 4'h9 && ty == 7) p = 4'hD;
`endif
        model[ty*8 + tx] = p;
        model[fy*8 + fx] = 4'h0;
    endtask

    task automatic read_sq(input int x, input int y, output logic [3:0] v);
        view_x = 3'(x);
        view_y = 3'(y);
        step();
        v = piece_out;
    endtask

    task automatic wait_init(output int busy, output int changed, output int spurious);
        busy = 0; changed = 0; spurious = 0;
        while (init_busy && busy < 200) begin
            busy++;
            if (move_ready || move_done || move_err) spurious++;
            if (board_changed) changed++;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            if (board_changed) changed++;
            if (move_done || move_err) spurious++;
            step();
        end
    endtask

    task automatic run_move(input int fx, input int fy, input int tx, input int ty, input int ng_at,
                            output int lat_done, output int lat_err, output logic [3:0] cap,
                            output int n_changed, output logic ready_after, output logic busy_seen);
        lat_done = -1; lat_err = -1; cap = 4'h0; n_changed = 0; ready_after = 1'b0; busy_seen = 1'b0;
        for (int w = 0; w < 20 && !move_ready; w++) step();
        from_x = 3'(fx); from_y = 3'(fy); to_x = 3'(tx); to_y = 3'(ty);
        move_valid = 1'b1;
        step();
        move_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            new_game = (c == ng_at);
            if (init_busy) busy_seen = 1'b1;
            if (board_changed) n_changed++;
            if (move_done) begin lat_done = c; cap = captured; end
            if (move_err) begin lat_err = c; cap = captured; end
            if (move_done || move_err) break;
            step();
        end
        step();
        new_game = 1'b0;
        ready_after = move_ready;
        if (init_busy) busy_seen = 1'b1;
        if (board_changed) n_changed++;
    endtask

    task automatic test_reset();
        int busy, changed, spurious;
        logic [3:0] v;
        resetn = 1'b0;
        step(); step(); step();
        checks++; if (piece_out !== 4'h0) begin failures++; $display("FAIL rst_piece_out: got %h expected 0", piece_out); end
        checks++; if (move_ready !== 1'b0) begin failures++; $display("FAIL rst_move_ready: got %b expected 0", move_ready); end
        checks++; if (move_done !== 1'b0) begin failures++; $display("FAIL rst_move_done: got %b expected 0", move_done); end
        checks++; if (move_err !== 1'b0) begin failures++; $display("FAIL rst_move_err: got %b expected 0", move_err); end
        checks++; if (captured !== 4'h0) begin failures++; $display("FAIL rst_captured: got %h expected 0", captured); end
        checks++; if (board_changed !== 1'b0) begin failures++; $display("FAIL rst_board_changed: got %b expected 0", board_changed); end
        checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL rst_init_busy: got %b expected 1", init_busy); end
        resetn = 1'b1;
        wait_init(busy, changed, spurious);
        checks++; if (busy !== 64) begin failures++; $display("FAIL init_busy_cycles: got %0d expected 64", busy); end
        checks++; if (changed !== 1) begin failures++; $display("FAIL init_changed_pulses: got %0d expected 1", changed); end
        checks++; if (spurious !== 0) begin failures++; $display("FAIL init_spurious: got %0d expected 0", spurious); end
        checks++; if (move_ready !== 1'b1) begin failures++; $display("FAIL init_ready: got %b expected 1", move_ready); end
        model_reset();
        read_sq(3, 0, v);
        checks++; if (v !== 4'hD) begin failures++; $display("FAIL init_sq30: got %h expected d", v); end
        read_sq(4, 7, v);
        checks++; if (v !== 4'h6) begin failures++; $display("FAIL init_sq47: got %h expected 6", v); end
        read_sq(0, 1, v);
        checks++; if (v !== 4'h9) begin failures++; $display("FAIL init_sq01: got %h expected 9", v); end
        read_sq(5, 4, v);
        checks++; if (v !== 4'h0) begin failures++; $display("FAIL init_sq54: got %h expected 0", v); end
        for (int i = 0; i < 64; i++) begin
            read_sq(i % 8, i / 8, v);
            checks++; if (v !== model[i]) begin failures++; $display("FAIL init_scan[%0d]: got %h expected %h", i, v, model[i]); end
        end
    endtask

    task automatic test_plain_move();
        int ld, le, nc; logic [3:0] cap, v; logic rdy, bs;
        run_move(4, 6, 4, 4, 0, ld, le, cap, nc, rdy, bs);
        model_apply(4, 6, 4, 4);
        checks++; if (ld !== 4) begin failures++; $display("FAIL plain_done_latency: got %0d expected 4", ld); end
        checks++; if (le !== -1) begin failures++; $display("FAIL plain_err: got %0d expected -1", le); end
        checks++; if (cap !== 4'h0) begin failures++; $display("FAIL plain_captured: got %h expected 0", cap); end
        checks++; if (nc !== 1) begin failures++; $display("FAIL plain_changed: got %0d expected 1", nc); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL plain_ready_n5: got %b expected 1", rdy); end
        read_sq(4, 4, v);
        checks++; if (v !== 4'h1) begin failures++; $display("FAIL plain_dst: got %h expected 1", v); end
        read_sq(4, 6, v);
        checks++; if (v !== 4'h0) begin failures++; $display("FAIL plain_src: got %h expected 0", v); end
    endtask

    task automatic test_capture();
        int ld, le, nc; logic [3:0] cap, v; logic rdy, bs;
        run_move(3, 6, 3, 1, 0, ld, le, cap, nc, rdy, bs);
        model_apply(3, 6, 3, 1);
        checks++; if (cap !== 4'h9) begin failures++; $display("FAIL cap_pawn: got %h expected 9", cap); end
        run_move(3, 1, 4, 0, 0, ld, le, cap, nc, rdy, bs);
        model_apply(3, 1, 4, 0);
        checks++; if (ld !== 4) begin failures++; $display("FAIL cap_latency: got %0d expected 4", ld); end
        checks++; if (cap !== 4'hE) begin failures++; $display("FAIL cap_king: got %h expected e", cap); end
        read_sq(4, 0, v);
`ifdef BOARD_PROMOTION_EN
        checks++; if (v !== 4'h5) begin failures++; $display("FAIL cap_promoted: got %h expected 5", v); end
`else
        checks++; if (v !== 4'h1) begin failures++; $display("FAIL cap_unpromoted: got %h expected 1", v); end
`endif
        read_sq(3, 1, v);
        checks++; if (v !== 4'h0) begin failures++; $display("FAIL cap_src_cleared: got %h expected 0", v); end
    endtask

    task automatic test_reject();
        int ld, le, nc; logic [3:0] cap; logic rdy, bs;
        run_move(2, 3, 2, 4, 0, ld, le, cap, nc, rdy, bs);
        checks++; if (le !== 2) begin failures++; $display("FAIL err_latency: got %0d expected 2", le); end
        checks++; if (ld !== -1) begin failures++; $display("FAIL err_done: got %0d expected -1", ld); end
        checks++; if (nc !== 0) begin failures++; $display("FAIL err_changed: got %0d expected 0", nc); end
        checks++; if (cap !== 4'h0) begin failures++; $display("FAIL err_captured: got %h expected 0", cap); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL err_ready: got %b expected 1", rdy); end
    endtask

    task automatic test_same_square();
        int ld, le, nc; logic [3:0] cap, v; logic rdy, bs;
        run_move(1, 7, 1, 7, 0, ld, le, cap, nc, rdy, bs);
        checks++; if (ld !== 2) begin failures++; $display("FAIL same_latency: got %0d expected 2", ld); end
        checks++; if (nc !== 0) begin failures++; $display("FAIL same_changed: got %0d expected 0", nc); end
        checks++; if (cap !== 4'h0) begin failures++; $display("FAIL same_captured: got %h expected 0", cap); end
        read_sq(1, 7, v);
        checks++; if (v !== 4'h2) begin failures++; $display("FAIL same_piece: got %h expected 2", v); end
    endtask

    task automatic test_back_to_back();
        int ld, le, nc, fx, fy, tx, ty, s, d, ng, exp_ld, exp_le, exp_nc;
        int occ[$];
        logic [3:0] cap, exp_cap, v; logic rdy, bs;
        for (int m = 0; m < 40; m++) begin
            occ.delete();
            for (int i = 0; i < 64; i++) if (model[i] != 4'h0) occ.push_back(i);
            if ($urandom_range(0, 4) != 0) s = occ[$urandom_range(0, occ.size() - 1)];
            else s = int'($urandom_range(0, 63));
            d = ($urandom_range(0, 7) == 0) ? s : int'($urandom_range(0, 63));
            fx = s % 8; fy = s / 8; tx = d % 8; ty = d / 8;
            ng = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            if (model[s] == 4'h0) begin exp_ld = -1; exp_le = 2; exp_cap = 4'h0; exp_nc = 0; end
            else if (s == d) begin exp_ld = 2; exp_le = -1; exp_cap = 4'h0; exp_nc = 0; end
            else begin exp_ld = 4; exp_le = -1; exp_cap = model[d]; exp_nc = 1; end
            run_move(fx, fy, tx, ty, ng, ld, le, cap, nc, rdy, bs);
            model_apply(fx, fy, tx, ty);
            checks++; if (ld !== exp_ld) begin failures++; $display("FAIL rnd_done[%0d]: got %0d expected %0d", m, ld, exp_ld); end
            checks++; if (le !== exp_le) begin failures++; $display("FAIL rnd_err[%0d]: got %0d expected %0d", m, le, exp_le); end
            checks++; if (cap !== exp_cap) begin failures++; $display("FAIL rnd_captured[%0d]: got %h expected %h", m, cap, exp_cap); end
            checks++; if (nc !== exp_nc) begin failures++; $display("FAIL rnd_changed[%0d]: got %0d expected %0d", m, nc, exp_nc); end
            checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL rnd_ready[%0d]: got %b expected 1", m, rdy); end
            checks++; if (bs !== 1'b0) begin failures++; $display("FAIL rnd_newgame_ignored[%0d]: got %b expected 0", m, bs); end
        end
        for (int i = 0; i < 64; i++) begin
            read_sq(i % 8, i / 8, v);
            checks++; if (v !== model[i]) begin failures++; $display("FAIL rnd_scan[%0d]: got %h expected %h", i, v, model[i]); end
        end
    endtask

    task automatic test_new_game_priority();
        int busy, changed, spurious;
        logic [3:0] v;
        for (int w = 0; w < 20 && !move_ready; w++) step();
        from_x = 3'd0; from_y = 3'd6; to_x = 3'd0; to_y = 3'd5;
        new_game = 1'b1; move_valid = 1'b1;
        step();
        new_game = 1'b0; move_valid = 1'b0;
        checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL ng_init_entered: got %b expected 1", init_busy); end
        checks++; if (move_ready !== 1'b0) begin failures++; $display("FAIL ng_ready_low: got %b expected 0", move_ready); end
        wait_init(busy, changed, spurious);
        checks++; if (busy !== 64) begin failures++; $display("FAIL ng_busy_cycles: got %0d expected 64", busy); end
        checks++; if (spurious !== 0) begin failures++; $display("FAIL ng_spurious: got %0d expected 0", spurious); end
        checks++; if (changed !== 1) begin failures++; $display("FAIL ng_changed: got %0d expected 1", changed); end
        model_reset();
        for (int i = 0; i < 64; i++) begin
            read_sq(i % 8, i / 8, v);
            checks++; if (v !== model[i]) begin failures++; $display("FAIL ng_scan[%0d]: got %h expected %h", i, v, model[i]); end
        end
    endtask

    task automatic test_reset_mid_move();
        int busy, changed, spurious, dones;
        logic [3:0] v;
        dones = 0;
        for (int w = 0; w < 20 && !move_ready; w++) step();
        from_x = 3'd4; from_y = 3'd6; to_x = 3'd4; to_y = 3'd4;
        move_valid = 1'b1;
        step();
        move_valid = 1'b0;
        if (move_done) dones++;
        step();
        if (move_done) dones++;
        resetn = 1'b0;
        step();
        if (move_done) dones++;
        checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL mid_rst_busy: got %b expected 1", init_busy); end
        resetn = 1'b1;
        wait_init(busy, changed, spurious);
        checks++; if (dones !== 0) begin failures++; $display("FAIL mid_rst_done: got %0d expected 0", dones); end
        checks++; if (busy !== 64) begin failures++; $display("FAIL mid_rst_busy_cycles: got %0d expected 64", busy); end
        checks++; if (spurious !== 0) begin failures++; $display("FAIL mid_rst_spurious: got %0d expected 0", spurious); end
        model_reset();
        read_sq(4, 6, v);
        checks++; if (v !== 4'h1) begin failures++; $display("FAIL mid_rst_sq46: got %h expected 1", v); end
        read_sq(4, 4, v);
        checks++; if (v !== 4'h0) begin failures++; $display("FAIL mid_rst_sq44: got %h expected 0", v); end
    endtask

    initial begin
        test_reset();
        test_plain_move();
        test_capture();
        test_reject();
        test_same_square();
        test_back_to_back();
        test_new_game_priority();
        test_reset_mid_move();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chess_board_mem.md
# chess_board_mem

Board-state store for the chess display path. Holds the 8x8 array of 4-bit piece codes, serves the view renderer's square-by-square read (`view_x`/`view_y` in, piece code out), and executes move commands from the game controller through a valid/ready handshake. On reset or new game it loads the standard starting position. It pulses `board_changed` so the view FSM knows to redraw.

## Interface
Parameters:
- `INIT_CYCLES`, 64: squares written by the init sequence. Fixed at 64; exposed only for bench visibility.

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: reset is synchronous and active-low; one clock domain.
- `view_x` in 3: read column, 0..7.
- `view_y` in 3: read row, 0..7.
- `piece_out` out 4: registered piece code at (`view_x`, `view_y`).
- `new_game` in 1: request to reload the starting position.
- `move_valid` in 1: move command present.
- `move_ready` out 1: block can accept a move.
- `from_x`, `from_y`, `to_x`, `to_y` in 3 each: move source and destination.
- `move_done` out 1: one-cycle pulse when a move completes.
- `move_err` out 1: one-cycle pulse when a move is rejected.
- `captured` out 4: piece code found at the destination. Valid with `move_done` and held until the next accept.
- `init_busy` out 1: starting-position load in progress.
- `board_changed` out 1: one-cycle pulse whenever board contents change.

## Operation
- **Piece code:** `bit3` = colour (0 white, 1 black); `bits[2:0]` = type (0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king; 7 reserved and never written). 4'h0 is an empty square.
- **Storage:** 64 x 4 register array, index = {y, x}.
- **Starting position:**
  - y=0 black back rank, x=0..7: R N B Q K B N R (x=3 queen, x=4 king).
  - y=1 black pawns.
  - y=2..5 empty.
  - y=6 white pawns.
  - y=7 white back rank, same order.
- **FSM states:** INIT, IDLE, READ_SRC, WRITE_DST, CLEAR_SRC, DONE.
  - **INIT:** a 6-bit counter writes one square per cycle, indices 0..63. After index 63 is written, go to IDLE.
  - **IDLE:** `move_ready` = 1. If `new_game` = 1, go to INIT (takes priority over `move_valid` in the same cycle). Otherwise, on `move_valid` & `move_ready`, latch the four coordinates and go to READ_SRC.
  - **READ_SRC:** latch the source piece and the destination piece.
    - Source empty: go to DONE with the error flag set.
    - from == to: go to DONE with no write and `captured` = 0.
    - Otherwise: go to WRITE_DST.
  - **WRITE_DST:** write the source piece to the destination, then go to CLEAR_SRC.
  - **CLEAR_SRC:** write 4'h0 to the source, then go to DONE.
  - **DONE:** pulse `move_done` (or `move_err` on an error), then return to IDLE.
    - `board_changed` pulses only if a write occurred.
    - `captured` = the latched destination piece. On an error, `captured` = 0.
- **View read port:** independent of the FSM and never stalled by moves.
  - `piece_out` <= array[{view_y, view_x}] on every edge.
  - While `init_busy` = 1, `piece_out` <= 4'h0.
- **Ignored inputs:**
  - `new_game` outside IDLE.
  - `move_valid` while `move_ready` = 0. The controller must hold the command until it is accepted.
- **Reset mid-operation:** `resetn` = 0 on any edge abandons the current move and forces INIT with the counter at 0. No `move_done` is produced.

## Timing
- **Reset values** (edge with `resetn` = 0):
  - `piece_out` = 0, `move_ready` = 0, `move_done` = 0, `move_err` = 0, `captured` = 0, `board_changed` = 0, `init_busy` = 1.
  - State = INIT, counter = 0.
- **Init:**
  - 64 cycles; index k is written on the (k+1)th edge after `resetn` rises.
  - The edge that writes index 63 also sets state = IDLE, `init_busy` = 0, `move_ready` = 1, and `board_changed` = 1 for that one cycle.
- **Read latency:** 1 cycle. Address stable in cycle N gives `piece_out` valid in cycle N+1.
- **Move latency:** for a handshake in cycle N:
  - READ_SRC in N+1, WRITE_DST in N+2, CLEAR_SRC in N+3.
  - DONE in N+4, with `move_done`/`move_err` high in N+4.
  - IDLE and `move_ready` = 1 in N+5.
  - A from == to move or an error move skips straight to DONE in N+2.
- **Read/write overlap:** a view read of a square written on edge E returns the new value when the address is presented in the cycle after E.
- **Back-to-back moves:** throughput is one move per 5 cycles.

## Configuration
- **`BOARD_PROMOTION_EN` defined:** in WRITE_DST, a pawn written to its promotion rank is stored as a queen of the same colour. That means a white pawn reaching y=0 is stored as 4'h5, and a black pawn reaching y=7 is stored as 4'hD.
- **Not defined:** the piece is written unchanged.

## Test plan
- **Reset and init:** hold `resetn` low 3 cycles, then release. Require `init_busy` = 1 for exactly 64 cycles, one `board_changed` pulse, then reads give:
  - (3,0) = 4'hD, (4,7) = 4'h6, (0,1) = 4'h9, (5,4) = 4'h0.
- **Plain move:** move (4,6)->(4,4) accepted in cycle N. Require:
  - `move_done` in N+4 with `captured` = 0.
  - Reads give (4,4) = 4'h1 and (4,6) = 4'h0.
  - `move_ready` back high in N+5.
- **Capture and rejects:**
  - Place a white pawn at (3,1) via moves, then move (3,1)->(4,0). Require `captured` = 4'hE, and with `BOARD_PROMOTION_EN` defined, (4,0) = 4'h5.
  - Move from empty (2,3). Require `move_err` in N+2 and no `board_changed`.
- **Same-square move:** (1,7)->(1,7). Require `move_done` in N+2, no `board_changed`, and (1,7) still 4'h2.
- **Reset mid-move:** drop `resetn` in N+2 of a move. Require no `move_done` and a full init restart; after 64 cycles, (4,6) = 4'h1.
- **New game priority:** assert `new_game` and `move_valid` together in IDLE. Require INIT entered and the move not accepted; `move_ready` = 0 until init completes.
